// File: rtl/mem_responder.sv
// mem_responder: 256 x 8 byte memory that a byte-stream loader fills while the
// processor is held in reset, and that the processor then reads and writes.
//
// Operation
//   LOAD : loader bytes (ld_valid) are written to consecutive addresses from 0.
//          The processor is held in reset and its write strobe is ignored.
//          The image ends on a byte flagged ld_last or on the LOAD_LEN-th byte,
//          whichever comes first. That final byte is still written.
//   RUN  : the processor is released and its writes are performed. RUN is left
//          only through reset.
//
// Parameters
//   LOAD_LEN  maximum image length in bytes (1..256)
//   PROT_TOP  highest write-protected address (used only with MEM_WRPROT_EN)
//
// Build option
//   MEM_WRPROT_EN  when defined, RUN-state processor writes to adr <= PROT_TOP
//                  are dropped and raise the sticky wr_viol flag. Loader writes
//                  are never protected. When undefined, wr_viol is tied low.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   adr        in   8-bit processor byte address
//   writedata  in   8-bit processor store data
//   memwrite   in   processor write strobe
//   memdata    out  mem[adr], combinational
//   ld_valid   in   loader byte valid
//   ld_data    in   loader byte
//   ld_last    in   final loader byte (qualified by ld_valid)
//   ld_ready   out  responder accepts a loader byte
//   cpu_reset  out  holds the processor in reset while loading
//   load_done  out  image loaded, processor running
//   wr_viol    out  sticky protected-write flag

module mem_responder #(
    parameter int unsigned LOAD_LEN = 256,
    parameter logic [7:0]  PROT_TOP = 8'h7F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] adr,
    input  logic [7:0] writedata,
    input  logic       memwrite,
    output logic [7:0] memdata,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    input  logic       ld_last,
    output logic       ld_ready,
    output logic       cpu_reset,
    output logic       load_done,
    output logic       wr_viol
);

    // Pointer value of the last byte the image may occupy. LOAD_LEN = 256
    // maps to 8'hFF, so the length limit fires just before the pointer wraps.
    localparam logic [7:0] LAST_PTR = 8'(LOAD_LEN - 1);

    typedef enum logic [0:0] {
        StLoad = 1'b0,
        StRun  = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] ptr_q, ptr_d;

    // Single write port shared by the loader and the processor. The two
    // sources are mutually exclusive by state, so no arbitration is needed.
    logic       mem_we;
    logic [7:0] mem_wa;
    logic [7:0] mem_wd;

    logic [7:0] mem [256];

`ifdef MEM_WRPROT_EN
    logic viol_set;
    logic wr_viol_q;
`endif

    // ------------------------------------------------------------------
    // State and pointer registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StLoad;
            ptr_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, pointer and write-port control
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mem_we  = 1'b0;
        mem_wa  = ptr_q;
        mem_wd  = ld_data;
`ifdef MEM_WRPROT_EN
        viol_set = 1'b0;
`endif

        unique case (state_q)
            StLoad: begin
                // ld_ready is high throughout LOAD, so ld_valid alone
                // qualifies a transfer. memwrite is deliberately ignored.
                if (ld_valid) begin
                    mem_we = 1'b1;
                    mem_wa = ptr_q;
                    mem_wd = ld_data;
                    ptr_d  = ptr_q + 8'h01;
                    if (ld_last || (ptr_q == LAST_PTR)) begin
                        state_d = StRun;
                    end
                end
            end

            StRun: begin
                // Loader inputs are ignored here; the pointer stays frozen.
                if (memwrite) begin
                    mem_wa = adr;
                    mem_wd = writedata;
`ifdef MEM_WRPROT_EN
                    if (adr <= PROT_TOP) begin
                        viol_set = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                    end
`else
                    mem_we = 1'b1;
`endif
                end
            end

            default: begin
                state_d = StLoad;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage: never reset, so contents survive a reload request.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Asynchronous read: a same-cycle write shows up only after the edge.
    assign memdata = mem[adr];

    // ------------------------------------------------------------------
    // Status outputs, decoded straight from the state register so they
    // switch on the transition edge and react to reset without a clock.
    // ------------------------------------------------------------------
    assign ld_ready  = (state_q == StLoad);
    assign cpu_reset = (state_q == StLoad);
    assign load_done = (state_q == StRun);

    // ------------------------------------------------------------------
    // Write-protection violation flag
    // ------------------------------------------------------------------
`ifdef MEM_WRPROT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_viol_q <= 1'b0;
        end else if (viol_set) begin
            wr_viol_q <= 1'b1;
        end
    end

    assign wr_viol = wr_viol_q;
`else
    // PROT_TOP only matters when protection is built in.
    logic unused_prot_top;
    assign unused_prot_top = ^PROT_TOP;

    assign wr_viol = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder. Two instances: dut_a with the default
// 256-byte image limit, dut_b with a 4-byte limit. A behavioural model (memory
// array, loading flag, accepted-byte count) predicts every observed value.

module tb_mem_responder;

    localparam int unsigned LEN_B    = 4;
    localparam logic [7:0]  PROT_TOP = 8'h7F;
`ifdef MEM_WRPROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a signals
    logic       a_reset, a_memwrite, a_ld_valid, a_ld_last;
    logic       a_ld_ready, a_cpu_reset, a_load_done, a_wr_viol;
    logic [7:0] a_adr, a_writedata, a_memdata, a_ld_data;
    // dut_b signals
    logic       b_reset, b_memwrite, b_ld_valid, b_ld_last;
    logic       b_ld_ready, b_cpu_reset, b_load_done, b_wr_viol;
    logic [7:0] b_adr, b_writedata, b_memdata, b_ld_data;

    mem_responder dut_a (
        .clk       (clk),
        .reset     (a_reset),
        .adr       (a_adr),
        .writedata (a_writedata),
        .memwrite  (a_memwrite),
        .memdata   (a_memdata),
        .ld_valid  (a_ld_valid),
        .ld_data   (a_ld_data),
        .ld_last   (a_ld_last),
        .ld_ready  (a_ld_ready),
        .cpu_reset (a_cpu_reset),
        .load_done (a_load_done),
        .wr_viol   (a_wr_viol)
    );

    mem_responder #(
        .LOAD_LEN (LEN_B)
    ) dut_b (
        .clk       (clk),
        .reset     (b_reset),
        .adr       (b_adr),
        .writedata (b_writedata),
        .memwrite  (b_memwrite),
        .memdata   (b_memdata),
        .ld_valid  (b_ld_valid),
        .ld_data   (b_ld_data),
        .ld_last   (b_ld_last),
        .ld_ready  (b_ld_ready),
        .cpu_reset (b_cpu_reset),
        .load_done (b_load_done),
        .wr_viol   (b_wr_viol)
    );

    int passed = 0;
    int total  = 0;

    // Model of dut_a
    logic [7:0] ma_mem [256];
    bit         ma_loading;
    int         ma_count;
    bit         ma_viol;

    // Model of dut_b
    logic [7:0] mb_mem [256];
    int         mb_count;

    task automatic a_model_reset();
        ma_loading = 1'b1;
        ma_count   = 0;
        ma_viol    = 1'b0;
    endtask

    // Apply one clock edge's worth of behaviour to the model, from current inputs.
    task automatic a_model_edge();
        if (ma_loading) begin
            if (a_ld_valid) begin
                ma_mem[ma_count % 256] = a_ld_data;
                ma_count++;
                if (a_ld_last || ma_count == 256) ma_loading = 1'b0;
            end
        end else if (a_memwrite) begin
            if (PROT && a_adr <= PROT_TOP) ma_viol = 1'b1;
            else ma_mem[a_adr] = a_writedata;
        end
    endtask

    task automatic a_step();
        a_model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic a_reset_cycle();
        a_reset = 1'b1;
        a_model_reset();
        @(posedge clk);
        #1;
        a_reset = 1'b0;
    endtask

    task automatic a_idle();
        a_memwrite = 1'b0;
        a_ld_valid = 1'b0;
        a_ld_last  = 1'b0;
    endtask

    // Async reset assertion between edges, outputs must follow immediately.
    task automatic test_reset();
        #3;
        a_reset = 1'b1;
        a_model_reset();
        #1;
        total++; if (a_ld_ready !== 1'b1) $display("FAIL reset_ld_ready: got %b want 1", a_ld_ready); else passed++;
        total++; if (a_cpu_reset !== 1'b1) $display("FAIL reset_cpu_reset: got %b want 1", a_cpu_reset); else passed++;
        total++; if (a_load_done !== 1'b0) $display("FAIL reset_load_done: got %b want 0", a_load_done); else passed++;
        total++; if (a_wr_viol !== 1'b0) $display("FAIL reset_wr_viol: got %b want 0", a_wr_viol); else passed++;
        @(posedge clk);
        #1;
        a_reset = 1'b0;
    endtask

    // 256-byte image with no ld_last: limit ends the load on the 256th byte.
    task automatic test_full_load();
        logic [7:0] extra;
        for (int i = 0; i < 256; i++) begin
            a_ld_valid = 1'b1;
            a_ld_data  = 8'($urandom);
            a_ld_last  = 1'b0;
            #1;
            total++;
            if (a_load_done !== !ma_loading)
                $display("FAIL full_load_done[%0d]: got %b want %b", i, a_load_done, !ma_loading);
            else passed++;
            a_step();
        end
        total++; if (a_load_done !== 1'b1) $display("FAIL full_done: got %b want 1", a_load_done); else passed++;
        total++; if (a_cpu_reset !== 1'b0) $display("FAIL full_cpu_reset: got %b want 0", a_cpu_reset); else passed++;
        total++; if (a_ld_ready !== 1'b0) $display("FAIL full_ld_ready: got %b want 0", a_ld_ready); else passed++;
        // A further byte must be refused, so mem[0] keeps the first image byte.
        extra = ma_mem[0] ^ 8'hFF;
        a_ld_data = extra;
        a_step();
        a_idle();
        for (int i = 0; i < 256; i++) begin
            a_adr = 8'(i);
            #1;
            total++;
            if (a_memdata !== ma_mem[i])
                $display("FAIL full_mem[%0d]: got %h want %h", i, a_memdata, ma_mem[i]);
            else passed++;
        end
    endtask

    // Short image with ld_last; memwrite ignored in LOAD, honoured in RUN.
    task automatic test_short_load();
        logic [7:0] old;
        a_reset_cycle();
        a_adr       = 8'h10;
        a_writedata = 8'h55;
        a_memwrite  = 1'b1;
        a_step();
        a_memwrite = 1'b0;
        #1;
        total++; if (a_memdata !== ma_mem[16]) $display("FAIL load_memwrite_ignored: got %h want %h", a_memdata, ma_mem[16]); else passed++;
        for (int i = 0; i < 4; i++) begin
            a_ld_valid = 1'b1;
            a_ld_data  = 8'hA0 + 8'(i);
            a_ld_last  = (i == 3);
            a_step();
            total++;
            if (a_cpu_reset !== ma_loading)
                $display("FAIL short_cpu_reset[%0d]: got %b want %b", i, a_cpu_reset, ma_loading);
            else passed++;
            total++;
            if (a_load_done !== !ma_loading)
                $display("FAIL short_load_done[%0d]: got %b want %b", i, a_load_done, !ma_loading);
            else passed++;
        end
        a_idle();
        #1;
        total++; if (a_ld_ready !== 1'b0) $display("FAIL short_ld_ready: got %b want 0", a_ld_ready); else passed++;
        for (int i = 0; i < 4; i++) begin
            a_adr = 8'(i);
            #1;
            total++;
            if (a_memdata !== ma_mem[i]) $display("FAIL short_mem[%0d]: got %h want %h", i, a_memdata, ma_mem[i]);
            else passed++;
        end
        // RUN write: memdata shows the old byte until the edge.
        a_adr       = 8'h10;
        a_writedata = 8'h55;
        a_memwrite  = 1'b1;
        old         = ma_mem[16];
        #1;
        total++; if (a_memdata !== old) $display("FAIL run_read_old: got %h want %h", a_memdata, old); else passed++;
        a_step();
        a_memwrite = 1'b0;
        #1;
        total++; if (a_memdata !== ma_mem[16]) $display("FAIL run_write_10: got %h want %h", a_memdata, ma_mem[16]); else passed++;
        total++; if (a_wr_viol !== ma_viol) $display("FAIL run_viol_10: got %b want %b", a_wr_viol, ma_viol); else passed++;
    endtask

    // Reset mid-load from RUN-less partial image; reload starts at address 0.
    task automatic test_mid_reset();
        a_reset_cycle();
        for (int i = 0; i < 2; i++) begin
            a_ld_valid = 1'b1;
            a_ld_data  = 8'($urandom);
            a_ld_last  = 1'b0;
            a_step();
        end
        a_ld_data = 8'($urandom);
        #2;
        a_reset = 1'b1;
        a_model_reset();
        #1;
        total++; if (a_cpu_reset !== 1'b1) $display("FAIL midrst_cpu_reset: got %b want 1", a_cpu_reset); else passed++;
        @(posedge clk);
        #1;
        a_reset    = 1'b0;
        a_ld_valid = 1'b1;
        a_ld_data  = 8'h11;
        a_ld_last  = 1'b1;
        a_step();
        a_idle();
        for (int i = 0; i < 3; i++) begin
            a_adr = 8'(i);
            #1;
            total++;
            if (a_memdata !== ma_mem[i]) $display("FAIL midrst_mem[%0d]: got %h want %h", i, a_memdata, ma_mem[i]);
            else passed++;
        end
        total++; if (a_load_done !== 1'b1) $display("FAIL midrst_done: got %b want 1", a_load_done); else passed++;
    endtask

    // Protected and unprotected RUN writes, then random RUN traffic.
    task automatic test_wrprot();
        logic [7:0] probe [3];
        probe[0] = 8'h20;
        probe[1] = 8'h80;
        probe[2] = 8'h90;
        for (int i = 0; i < 3; i++) begin
            a_adr       = probe[i];
            a_writedata = ma_mem[probe[i]] ^ 8'h5A;
            a_memwrite  = 1'b1;
            a_step();
            a_memwrite = 1'b0;
            #1;
            total++;
            if (a_memdata !== ma_mem[probe[i]])
                $display("FAIL prot_mem[%h]: got %h want %h", probe[i], a_memdata, ma_mem[probe[i]]);
            else passed++;
            total++;
            if (a_wr_viol !== ma_viol) $display("FAIL prot_viol[%0d]: got %b want %b", i, a_wr_viol, ma_viol);
            else passed++;
        end
        for (int i = 0; i < 200; i++) begin
            a_adr       = 8'($urandom);
            a_writedata = 8'($urandom);
            a_memwrite  = 1'($urandom);
            a_ld_valid  = 1'($urandom);
            a_ld_data   = 8'($urandom);
            a_ld_last   = 1'($urandom);
            #1;
            total++;
            if (a_memdata !== ma_mem[a_adr])
                $display("FAIL rand_mem[%0d]: adr %h got %h want %h", i, a_adr, a_memdata, ma_mem[a_adr]);
            else passed++;
            total++;
            if (a_wr_viol !== ma_viol) $display("FAIL rand_viol[%0d]: got %b want %b", i, a_wr_viol, ma_viol);
            else passed++;
            a_step();
        end
        a_idle();
    endtask

    // Async reset from RUN: status returns immediately, memory is retained.
    task automatic test_reset_from_run();
        #2;
        a_reset = 1'b1;
        a_model_reset();
        #1;
        total++; if (a_load_done !== 1'b0) $display("FAIL runrst_load_done: got %b want 0", a_load_done); else passed++;
        total++; if (a_cpu_reset !== 1'b1) $display("FAIL runrst_cpu_reset: got %b want 1", a_cpu_reset); else passed++;
        total++; if (a_ld_ready !== 1'b1) $display("FAIL runrst_ld_ready: got %b want 1", a_ld_ready); else passed++;
        total++; if (a_wr_viol !== 1'b0) $display("FAIL runrst_wr_viol: got %b want 0", a_wr_viol); else passed++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            a_adr = 8'($urandom);
            #1;
            total++;
            if (a_memdata !== ma_mem[a_adr])
                $display("FAIL runrst_mem[%h]: got %h want %h", a_adr, a_memdata, ma_mem[a_adr]);
            else passed++;
        end
        a_reset = 1'b0;
    endtask

    // dut_b: 6 back-to-back bytes with a 4-byte limit; only 4 are accepted.
    task automatic test_load_len();
        mb_count = 0;
        @(posedge clk);
        #1;
        b_reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            b_ld_valid = 1'b1;
            b_ld_data  = 8'($urandom);
            b_ld_last  = 1'b0;
            #1;
            total++;
            if (b_ld_ready !== (mb_count < LEN_B))
                $display("FAIL len_ld_ready[%0d]: got %b want %b", i, b_ld_ready, (mb_count < LEN_B));
            else passed++;
            if (mb_count < LEN_B) begin
                mb_mem[mb_count] = b_ld_data;
                mb_count++;
            end
            @(posedge clk);
            #1;
        end
        b_ld_valid = 1'b0;
        #1;
        total++; if (b_load_done !== 1'b1) $display("FAIL len_load_done: got %b want 1", b_load_done); else passed++;
        total++; if (b_cpu_reset !== 1'b0) $display("FAIL len_cpu_reset: got %b want 0", b_cpu_reset); else passed++;
        for (int i = 0; i < 6; i++) begin
            b_adr = 8'(i);
            #1;
            total++;
            if (b_memdata !== mb_mem[i]) $display("FAIL len_mem[%0d]: got %h want %h", i, b_memdata, mb_mem[i]);
            else passed++;
        end
    endtask

    initial begin
        a_reset = 1'b0;
        a_adr = 8'h00;
        a_writedata = 8'h00;
        a_ld_data = 8'h00;
        a_idle();
        b_reset = 1'b1;
        b_adr = 8'h00;
        b_writedata = 8'h00;
        b_memwrite = 1'b0;
        b_ld_valid = 1'b0;
        b_ld_data = 8'h00;
        b_ld_last = 1'b0;

        test_reset();
        test_full_load();
        test_short_load();
        test_mid_reset();
        test_wrprot();
        test_reset_from_run();
        test_load_len();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
